s10077_emu: RTL and testbench

Synthesizable responder model of the S10077 line sensor. It consumes the SENSOR_CLK and ST signals that the sensor driver generates, and produces EOC and EOS with sensor-accurate sequencing. Used for on-board loopback, by wiring its EOC/EOS back into the driver's inputs, and as the sensor stand-in on driver benches. Runs entirely in the FPGA_CLK domain and treats SENSOR_CLK as a sampled data signal.

---
 rtl/s10077_pkg.sv | 6 +
 rtl/s10077_sync_edge.sv | 37 +++
 rtl/s10077_emu.sv | 144 ++++++++++++++
 tb/tb_s10077_emu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/s10077_pkg.sv
// s10077_pkg: shared state encoding and widths for the S10077 sensor responder
package s10077_pkg;
  typedef enum logic [2:0] {IDLE, INTEG, DELAY, READ, EOS} state_t;
  localparam int PIX_W = 11;
  localparam int DATA_W = 12;
endpackage

// File: rtl/s10077_sync_edge.sv
// s10077_sync_edge: multi-flop synchronizer with a registered rise detector
// Ports: clk, rst_n (synchronous, active-low); edge_in, lvl_in asynchronous inputs;
//   rise is a one-cycle pulse on a synchronized 0->1 of edge_in; level is lvl_in
//   synchronized through the same number of stages, so it lines up with rise.
module s10077_sync_edge
  import s10077_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic edge_in,
  input  logic lvl_in,
  output logic rise,
  output logic level
);
  logic [STAGES-1:0] e_q, e_d, l_q, l_d;
  logic p_q, p_d;
  always_comb begin
    e_d = {e_q[STAGES-2:0], edge_in};
    l_d = {l_q[STAGES-2:0], lvl_in};
    p_d = e_q[STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
      l_q <= '0;
      p_q <= 1'b0;
    end else begin
      e_q <= e_d;
      l_q <= l_d;
      p_q <= p_d;
    end
  end
  assign rise = e_q[STAGES-1] & ~p_q;
  assign level = l_q[STAGES-1];
endmodule

// File: rtl/s10077_emu.sv
// s10077_emu: S10077 line-sensor responder producing EOC/EOS from the driver's SENSOR_CLK and ST
// Ports: FPGA_CLK clock; FPGA_RST synchronous active-low reset; SENSOR_CLK, ST driver inputs
//   (sampled in FPGA_CLK); EOC, EOS, PIX_IDX, INTEG_CNT, BUSY, OVERRUN registered status;
//   PIX_DATA synthetic video sample.
// Optional: define S10077_EMU_VIDEO_EN to build the frame counter and PIX_DATA generator.
module s10077_emu
  import s10077_pkg::*;
#(
  parameter int PIXELS = 1024,
  parameter int START_DLY = 48,
  parameter int SYNC_STAGES = 2,
  parameter int INTEG_W = 21
) (
  input  logic               FPGA_CLK,
  input  logic               FPGA_RST,
  input  logic               SENSOR_CLK,
  input  logic               ST,
  output logic               EOC,
  output logic               EOS,
  output logic [PIX_W-1:0]   PIX_IDX,
  output logic [INTEG_W-1:0] INTEG_CNT,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic [DATA_W-1:0]  PIX_DATA
);
  localparam int DW = $clog2(START_DLY + 1);
  state_t state_q, state_d;
  logic [INTEG_W-1:0] integ_q, integ_d, icnt_q, icnt_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic eoc_q, eoc_d, eos_q, eos_d, busy_q, busy_d, ovr_q, ovr_d, stp_q, stp_d;
  logic sclk_rise, st_s;
  s10077_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(FPGA_CLK), .rst_n(FPGA_RST), .edge_in(SENSOR_CLK), .lvl_in(ST),
    .rise(sclk_rise), .level(st_s)
  );
  always_comb begin
    state_d = state_q;
    integ_d = integ_q;
    icnt_d = icnt_q;
    dly_d = dly_q;
    pix_d = pix_q;
    eoc_d = eoc_q;
    eos_d = eos_q;
    busy_d = busy_q;
    ovr_d = ovr_q;
    stp_d = stp_q;
    if (sclk_rise) begin
      stp_d = st_s;
      // the EOS state always exits on its one rise, so only DELAY/READ can overrun
      if ((state_q == DELAY || state_q == READ) && st_s && !stp_q) ovr_d = 1'b1;
      case (state_q)
        IDLE: if (st_s) begin
          state_d = INTEG;
          busy_d = 1'b1;
          integ_d = INTEG_W'(1);
        end
        INTEG: if (st_s) integ_d = ~&integ_q ? integ_q + 1'b1 : integ_q;
        else begin
          // the first ST-low rise is delay count 1, so START_DLY=1 reads out immediately
          icnt_d = integ_q;
          dly_d = DW'(1);
          state_d = START_DLY == 1 ? READ : DELAY;
          eoc_d = START_DLY == 1;
          pix_d = START_DLY == 1 ? '0 : pix_q;
        end
        DELAY: begin
          dly_d = dly_q + 1'b1;
          if (dly_d == DW'(START_DLY)) begin
            state_d = READ;
            eoc_d = 1'b1;
            pix_d = '0;
          end
        end
        READ: if (eoc_q) eoc_d = 1'b0;
        else if (pix_q == PIX_W'(PIXELS - 1)) begin
          state_d = s10077_pkg::EOS;
          eos_d = 1'b1;
        end else begin
          eoc_d = 1'b1;
          pix_d = pix_q + 1'b1;
        end
        s10077_pkg::EOS: begin
          eos_d = 1'b0;
          busy_d = st_s;
          state_d = st_s ? INTEG : IDLE;
          integ_d = st_s ? INTEG_W'(1) : integ_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge FPGA_CLK) begin
    if (!FPGA_RST) begin
      state_q <= IDLE;
      integ_q <= '0;
      icnt_q <= '0;
      dly_q <= '0;
      pix_q <= '0;
      eoc_q <= 1'b0;
      eos_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
      stp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      integ_q <= integ_d;
      icnt_q <= icnt_d;
      dly_q <= dly_d;
      pix_q <= pix_d;
      eoc_q <= eoc_d;
      eos_q <= eos_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
      stp_q <= stp_d;
    end
  end
`ifdef S10077_EMU_VIDEO_EN
  logic [7:0] frame_q, frame_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    frame_d = frame_q + 8'(sclk_rise && state_q == s10077_pkg::EOS);
    data_d = eoc_d && !eoc_q ? {pix_d, 1'b0} + DATA_W'(frame_q) : data_q;
  end
  always_ff @(posedge FPGA_CLK) begin
    if (!FPGA_RST) begin
      frame_q <= '0;
      data_q <= '0;
    end else begin
      frame_q <= frame_d;
      data_q <= data_d;
    end
  end
  assign PIX_DATA = data_q;
`else
  assign PIX_DATA = '0;
`endif
  assign EOC = eoc_q;
  assign EOS = eos_q;
  assign PIX_IDX = pix_q;
  assign INTEG_CNT = icnt_q;
  assign BUSY = busy_q;
  assign OVERRUN = ovr_q;
endmodule

// File: tb/tb_s10077_emu.sv
// tb_s10077_emu: directed bench for s10077_emu (default instance plus a PIXELS=1/START_DLY=1 instance)
module tb_s10077_emu;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, st = 1'b0, st_b = 1'b0;
  logic eoc_a, eos_a, busy_a, ovr_a, eoc_b, eos_b, busy_b, ovr_b;
  logic [10:0] pix_a, pix_b;
  logic [20:0] icnt_a;
  logic [3:0] icnt_b;
  logic [11:0] data_a, data_b;
  int n_cmp = 0, n_bad = 0;
  logic eoc_p = 1'b0, eos_p = 1'b0;
  int eoc_len = 0, eos_len = 0, n_eoc = 0, n_wbad = 0, n_pbad = 0, last_pix = 0;
  typedef struct {
    int n;
    logic st, eoc, eos, busy;
    logic [10:0] pix;
    logic [3:0] icnt;
    logic ovr;
  } vec_t;
  always #5 clk = ~clk;
  s10077_emu dut_a (
    .FPGA_CLK(clk), .FPGA_RST(rst_n), .SENSOR_CLK(sclk), .ST(st), .EOC(eoc_a), .EOS(eos_a),
    .PIX_IDX(pix_a), .INTEG_CNT(icnt_a), .BUSY(busy_a), .OVERRUN(ovr_a), .PIX_DATA(data_a)
  );
  s10077_emu #(.PIXELS(1), .START_DLY(1), .INTEG_W(4)) dut_b (
    .FPGA_CLK(clk), .FPGA_RST(rst_n), .SENSOR_CLK(sclk), .ST(st_b), .EOC(eoc_b), .EOS(eos_b),
    .PIX_IDX(pix_b), .INTEG_CNT(icnt_b), .BUSY(busy_b), .OVERRUN(ovr_b), .PIX_DATA(data_b)
  );
  // pulse widths and pixel sequencing of instance A, seen on every FPGA clock
  always @(negedge clk) begin
    if (!rst_n) begin
      eoc_p <= 1'b0;
      eos_p <= 1'b0;
      eoc_len <= 0;
      eos_len <= 0;
    end else begin
      eoc_p <= eoc_a;
      eos_p <= eos_a;
      eoc_len <= eoc_a ? eoc_len + 1 : 0;
      eos_len <= eos_a ? eos_len + 1 : 0;
      if (eoc_a && !eoc_p) begin
        n_eoc <= n_eoc + 1;
        if (pix_a != 11'd0 && int'(pix_a) != last_pix + 1) n_pbad <= n_pbad + 1;
        last_pix <= int'(pix_a);
      end
      if ((!eoc_a && eoc_p && eoc_len != 4) || (!eos_a && eos_p && eos_len != 4)) n_wbad <= n_wbad + 1;
    end
  end
  function automatic int vid(input int v);
`ifdef S10077_EMU_VIDEO_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction
  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask
  // one SENSOR_CLK period of 4 FPGA clocks; outputs have settled when it returns
  task automatic period();
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic run_to_eoc(output int n);
    n = 0;
    do begin
      period();
      n++;
    end while (!eoc_a && n < 200);
  endtask
  task automatic run_to_eos(output int n);
    n = 0;
    do begin
      period();
      n++;
    end while (!eos_a && n < 3000);
  endtask
  task automatic run_to_pix(input int p);
    int n;
    n = 0;
    do begin
      period();
      n++;
    end while (!(eoc_a && int'(pix_a) == p) && n < 3000);
    check("reach_pix", int'(pix_a), p);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[11];
    int n, base;
    tbl[0]  = '{20, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 4'd0,  1'b0};
    tbl[1]  = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 11'd0, 4'd15, 1'b0};
    tbl[2]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 4'd15, 1'b0};
    tbl[3]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 4'd15, 1'b0};
    tbl[4]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 4'd15, 1'b0};
    tbl[5]  = '{2,  1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 4'd15, 1'b0};
    tbl[6]  = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 11'd0, 4'd3,  1'b0};
    tbl[7]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 4'd3,  1'b1};
    tbl[8]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 4'd3,  1'b1};
    tbl[9]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 4'd3,  1'b1};
    tbl[10] = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 4'd3,  1'b1};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_eoc", int'(eoc_a), 0);
    check("rst_eos", int'(eos_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_pix", int'(pix_a), 0);
    check("rst_icnt", int'(icnt_a), 0);
    check("rst_ovr", int'(ovr_a), 0);
    check("rst_data", int'(data_a), 0);
    check("rst_b_busy", int'(busy_b), 0);
    check("rst_b_data", int'(data_b), 0);
    foreach (tbl[i]) begin
      st_b = tbl[i].st;
      repeat (tbl[i].n) period();
      check($sformatf("b%0d_eoc", i), int'(eoc_b), int'(tbl[i].eoc));
      check($sformatf("b%0d_eos", i), int'(eos_b), int'(tbl[i].eos));
      check($sformatf("b%0d_busy", i), int'(busy_b), int'(tbl[i].busy));
      check($sformatf("b%0d_pix", i), int'(pix_b), int'(tbl[i].pix));
      check($sformatf("b%0d_icnt", i), int'(icnt_b), int'(tbl[i].icnt));
      check($sformatf("b%0d_ovr", i), int'(ovr_b), int'(tbl[i].ovr));
    end
    st_b = 1'b0;
    st = 1'b1;
    repeat (100) period();
    check("s1_integ_busy", int'(busy_a), 1);
    check("s1_integ_icnt_held", int'(icnt_a), 0);
    base = n_eoc;
    st = 1'b0;
    repeat (10) period();
    repeat (40) @(negedge clk);
    check("s1_stall_eoc", int'(eoc_a), 0);
    check("s1_stall_busy", int'(busy_a), 1);
    check("s1_icnt", int'(icnt_a), 100);
    run_to_eoc(n);
    check("s1_first_eoc_rise", n + 10, 48);
    check("s1_first_pix", int'(pix_a), 0);
    run_to_eos(n);
    check("s1_eos_after", n, 2048);
    check("s1_eoc_count", n_eoc - base, 1024);
    check("s1_last_pix", int'(pix_a), 1023);
    check("s1_eos_busy", int'(busy_a), 1);
    check("s1_eos_eoc", int'(eoc_a), 0);
    check("s1_last_data", int'(data_a), vid(2046));
    period();
    check("s1_eos_clear", int'(eos_a), 0);
    check("s1_busy_clear", int'(busy_a), 0);
    st = 1'b1;
    repeat (20) period();
    base = n_eoc;
    st = 1'b0;
    run_to_pix(100);
    check("s2_ovr_before", int'(ovr_a), 0);
    st = 1'b1;
    period();
    st = 1'b0;
    check("s2_ovr_set", int'(ovr_a), 1);
    run_to_eos(n);
    check("s2_eoc_count", n_eoc - base, 1024);
    check("s2_ovr_sticky", int'(ovr_a), 1);
    check("s2_icnt", int'(icnt_a), 20);
    period();
    repeat (5) period();
    check("s2_idle_busy", int'(busy_a), 0);
    check("s2_idle_ovr", int'(ovr_a), 1);
    st = 1'b1;
    repeat (10) period();
    st = 1'b0;
    run_to_pix(5);
    check("s3_data_pix5", int'(data_a), vid(12));
    run_to_pix(500);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("mid_rst_eoc", int'(eoc_a), 0);
    check("mid_rst_eos", int'(eos_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_pix", int'(pix_a), 0);
    check("mid_rst_ovr", int'(ovr_a), 0);
    check("mid_rst_icnt", int'(icnt_a), 0);
    st = 1'b1;
    repeat (7) period();
    base = n_eoc;
    st = 1'b0;
    run_to_eoc(n);
    check("s4_first_eoc_rise", n, 48);
    run_to_eos(n);
    check("s4_eos_after", n, 2048);
    check("s4_eoc_count", n_eoc - base, 1024);
    check("s4_ovr", int'(ovr_a), 0);
    check("s4_icnt", int'(icnt_a), 7);
    check("s4_last_data", int'(data_a), vid(2046));
    period();
    check("s4_busy_clear", int'(busy_a), 0);
    check("pulse_widths", n_wbad, 0);
    check("pix_sequence", n_pbad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
